io_stream_dispatcher: RTL and testbench

//  Parametrised successor of the IO front-end FSM. Accepts packed words from the input bus
//  and splits each word into NUM_CH lanes of LANE_W bits (A, B, U, rest, ...).

---
 rtl/io_stream_dispatcher_pkg.sv | 15 +
 rtl/io_stream_dispatcher_if.sv | 25 ++
 rtl/io_stream_dispatcher_lane_slot.sv | 82 ++++++++
 rtl/io_stream_dispatcher.sv | 97 +++++++++
 tb/tb_io_stream_dispatcher.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/io_stream_dispatcher_pkg.sv
// Shared types and helpers for the IO stream dispatcher: FSM state encoding and lane slicing.
package io_stream_dispatcher_pkg;

  typedef enum logic [1:0] {
    IO_IDLE   = 2'b00,
    IO_DECOMP = 2'b01,
    IO_CALC   = 2'b10
  } io_state_e;

  // LSB position of lane `lane` inside a packed word of `lane_w`-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/io_stream_dispatcher_if.sv
// Word input bus and per-lane output bus of the IO stream dispatcher.
interface io_stream_dispatcher_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LANE_W = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*LANE_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_eob;
  logic [NUM_CH*LANE_W-1:0] lane_data;
  logic [NUM_CH-1:0]        lane_valid;
  logic [NUM_CH-1:0]        lane_ready;

  modport master (
    output in_valid, in_data, in_eob, lane_ready,
    input  in_ready, lane_data, lane_valid
  );

  modport slave (
    input  in_valid, in_data, in_eob, lane_ready,
    output in_ready, lane_data, lane_valid
  );

endinterface

// File: rtl/io_stream_dispatcher_lane_slot.sv
// One dispatcher lane: output register with valid/ready, object counter, finish flag and
// start pulse.
module io_stream_dispatcher_lane_slot #(
  parameter int unsigned LANE_W  = 8,
  parameter int unsigned NUM_OBJ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [LANE_W-1:0] data_in,
  input  logic              eob,
  input  logic              lane_ready,
  input  logic              new_obj,
  input  logic              clear,
  output logic [LANE_W-1:0] lane_data,
  output logic              lane_valid,
  output logic              start,
  output logic              finish,
  output logic              eob_err
);

  localparam int unsigned CntW = $clog2(NUM_OBJ + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(NUM_OBJ);

  logic [LANE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic              finish_q, finish_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic              load;

  // Finished lanes drop their slice of every accepted word.
  assign load    = accept & ~finish_q;
  assign cnt_inc = cnt_q + CntW'(1);
  assign eob_err = accept & eob & finish_q;

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    start_d  = 1'b0;
    finish_d = finish_q;
    cnt_d    = cnt_q;
    if (lane_ready) valid_d = 1'b0;
    if (load) begin
      data_d  = data_in;
      valid_d = 1'b1;
      if (eob) begin
        if (cnt_q != MaxCnt) cnt_d = cnt_inc;
        if (cnt_inc == MaxCnt) finish_d = 1'b1;
        else                   start_d  = 1'b1;
      end
    end
    if (new_obj && !finish_q) start_d = 1'b1;
    if (clear) begin
      cnt_d    = '0;
      finish_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      finish_q <= finish_d;
      cnt_q    <= cnt_d;
    end
  end

  assign lane_data  = data_q;
  assign lane_valid = valid_q;
  assign start      = start_q;
  assign finish     = finish_q;

endmodule

// File: rtl/io_stream_dispatcher.sv
// IO front-end: splits packed input words into lanes, tracks per-lane objects and sequences
// IDLE -> DECOMP -> CALC -> IDLE with the coordinator.
module io_stream_dispatcher
  import io_stream_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned LANE_W  = 8,
  parameter int unsigned NUM_OBJ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   int_req,
  input  logic                   process,
  io_stream_dispatcher_if.slave  bus,
  output logic [NUM_CH-1:0]      start,
  output logic [NUM_CH-1:0]      finish,
  input  logic                   coord_done,
  output logic [1:0]             state,
  output logic                   err
);

  io_state_e         state_q, state_d;
  logic              err_q, err_d;
  logic              accept;
  logic              new_obj;
  logic              clear;
  logic [NUM_CH-1:0] lane_ok;
  logic [NUM_CH-1:0] eob_err;

  // A lane can take a new slice if it is finished, empty, or draining this cycle.
  assign lane_ok      = finish | ~bus.lane_valid | bus.lane_ready;
  assign bus.in_ready = (state_q == IO_DECOMP) & (&lane_ok);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    err_d   = err_q | (|eob_err);
    new_obj = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IO_IDLE: begin
        if (int_req && !process) begin
          state_d = IO_DECOMP;
          new_obj = 1'b1;
        end
      end
      IO_DECOMP: begin
        if (int_req && process) begin
          if (&finish) state_d = IO_CALC;
          else         err_d   = 1'b1;
        end
      end
      IO_CALC: begin
        if (coord_done) begin
          state_d = IO_IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = IO_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IO_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    io_stream_dispatcher_lane_slot #(
      .LANE_W  (LANE_W),
      .NUM_OBJ (NUM_OBJ)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .accept     (accept),
      .data_in    (bus.in_data[lane_lsb(i, LANE_W) +: LANE_W]),
      .eob        (bus.in_eob[i]),
      .lane_ready (bus.lane_ready[i]),
      .new_obj    (new_obj),
      .clear      (clear),
      .lane_data  (bus.lane_data[lane_lsb(i, LANE_W) +: LANE_W]),
      .lane_valid (bus.lane_valid[i]),
      .start      (start[i]),
      .finish     (finish[i]),
      .eob_err    (eob_err[i])
    );
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_io_stream_dispatcher.sv
// Directed bench for io_stream_dispatcher: a 4x8 build through the full flow and a 2x16 build.
module tb_io_stream_dispatcher;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // 4 lanes x 8 bits
  logic       a_int_req, a_process, a_coord_done, a_err;
  logic [3:0] a_start, a_finish;
  logic [1:0] a_state;
  io_stream_dispatcher_if #(.NUM_CH(4), .LANE_W(8)) a_bus ();

  io_stream_dispatcher #(.NUM_CH(4), .LANE_W(8), .NUM_OBJ(4)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .int_req    (a_int_req),
    .process    (a_process),
    .bus        (a_bus),
    .start      (a_start),
    .finish     (a_finish),
    .coord_done (a_coord_done),
    .state      (a_state),
    .err        (a_err)
  );

  // 2 lanes x 16 bits
  logic       b_int_req, b_process, b_coord_done, b_err;
  logic [1:0] b_start, b_finish;
  logic [1:0] b_state;
  io_stream_dispatcher_if #(.NUM_CH(2), .LANE_W(16)) b_bus ();

  io_stream_dispatcher #(.NUM_CH(2), .LANE_W(16), .NUM_OBJ(4)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .int_req    (b_int_req),
    .process    (b_process),
    .bus        (b_bus),
    .start      (b_start),
    .finish     (b_finish),
    .coord_done (b_coord_done),
    .state      (b_state),
    .err        (b_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_int_req = 0; a_process = 0; a_coord_done = 0;
    a_bus.in_valid = 0; a_bus.in_data = '0; a_bus.in_eob = '0; a_bus.lane_ready = '0;
    b_int_req = 0; b_process = 0; b_coord_done = 0;
    b_bus.in_valid = 0; b_bus.in_data = '0; b_bus.in_eob = '0; b_bus.lane_ready = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_state", a_state, 2'b00);
    check("rst_in_ready", a_bus.in_ready, 1'b0);
    check("rst_lane_valid", a_bus.lane_valid, 4'h0);
    check("rst_lane_data", a_bus.lane_data, 32'h0);
    check("rst_start", a_start, 4'h0);
    check("rst_finish", a_finish, 4'h0);
    check("rst_err", a_err, 1'b0);

    // 1: enter DECOMP
    a_int_req = 1; a_process = 0;
    step();
    a_int_req = 0;
    check("t1_state", a_state, 2'b01);
    check("t1_start", a_start, 4'hF);
    check("t1_in_ready", a_bus.in_ready, 1'b1);
    step();
    check("t1_start_pulse", a_start, 4'h0);

    // 2: one word through all lanes
    a_bus.lane_ready = 4'hF; a_bus.in_valid = 1; a_bus.in_data = 32'hDDCCBBAA;
    step();
    a_bus.in_valid = 0;
    check("t2_lane_data", a_bus.lane_data, 32'hDDCCBBAA);
    check("t2_lane_valid", a_bus.lane_valid, 4'hF);

    // 3: backpressure on lane 2
    a_bus.lane_ready = 4'b1011;
    #1;
    check("t3_in_ready_stall", a_bus.in_ready, 1'b0);
    a_bus.in_valid = 1; a_bus.in_data = 32'h11223344;
    step();
    check("t3_lane_data_stable", a_bus.lane_data, 32'hDDCCBBAA);
    check("t3_lane_valid", a_bus.lane_valid, 4'b0100);
    a_bus.lane_ready = 4'hF;
    #1;
    check("t3_in_ready_release", a_bus.in_ready, 1'b1);
    step();
    a_bus.in_valid = 0;
    check("t3_lane_data_new", a_bus.lane_data, 32'h11223344);

    // 4: four objects on lane 0
    for (int k = 1; k <= 4; k++) begin
      a_bus.in_valid = 1; a_bus.in_data = 32'h01010101 * k; a_bus.in_eob = 4'b0001;
      step();
      check($sformatf("t4_start_w%0d", k), a_start, (k < 4) ? 4'b0001 : 4'b0000);
      check($sformatf("t4_finish_w%0d", k), a_finish, (k < 4) ? 4'b0000 : 4'b0001);
    end
    a_bus.in_valid = 0; a_bus.in_eob = 0;
    step();
    check("t4_valid_drained", a_bus.lane_valid, 4'h0);
    a_bus.in_valid = 1; a_bus.in_data = 32'hA1B2C3D4;
    step();
    a_bus.in_valid = 0;
    check("t4_drop_valid", a_bus.lane_valid, 4'b1110);
    check("t4_drop_data", a_bus.lane_data, 32'hA1B2C304);
    check("t4_err_clean", a_err, 1'b0);

    // 5: premature compute request, then the full flow
    for (int k = 0; k < 4; k++) begin
      a_bus.in_valid = 1; a_bus.in_data = 32'h0; a_bus.in_eob = 4'b0110;
      step();
    end
    a_bus.in_valid = 0; a_bus.in_eob = 0;
    check("t5_finish_0111", a_finish, 4'b0111);
    a_int_req = 1; a_process = 1;
    step();
    a_int_req = 0;
    check("t5_state_early", a_state, 2'b01);
    check("t5_err", a_err, 1'b1);
    for (int k = 0; k < 4; k++) begin
      a_bus.in_valid = 1; a_bus.in_data = 32'h0; a_bus.in_eob = 4'b1000;
      step();
    end
    a_bus.in_valid = 0; a_bus.in_eob = 0;
    check("t5_finish_all", a_finish, 4'hF);
    a_int_req = 1; a_process = 1;
    step();
    a_int_req = 0; a_process = 0;
    check("t5_state_calc", a_state, 2'b10);
    check("t5_calc_in_ready", a_bus.in_ready, 1'b0);
    a_coord_done = 1;
    step();
    a_coord_done = 0;
    check("t5_state_idle", a_state, 2'b00);
    check("t5_finish_clr", a_finish, 4'h0);
    check("t5_err_sticky", a_err, 1'b1);

    // 6: reset mid-DECOMP with pending lane words
    a_int_req = 1;
    step();
    a_int_req = 0;
    check("t6_start", a_start, 4'hF);
    a_bus.in_valid = 1; a_bus.in_data = 32'h55667788; a_bus.lane_ready = 4'hF;
    step();
    a_bus.in_valid = 0; a_bus.lane_ready = 4'b0101;
    step();
    check("t6_lane_valid", a_bus.lane_valid, 4'b1010);
    reset = 1;
    step();
    reset = 0;
    check("t6_state", a_state, 2'b00);
    check("t6_lane_valid_rst", a_bus.lane_valid, 4'h0);
    check("t6_lane_data_rst", a_bus.lane_data, 32'h0);
    check("t6_err_rst", a_err, 1'b0);
    check("t6_in_ready_rst", a_bus.in_ready, 1'b0);
    check("t6_start_rst", a_start, 4'h0);

    // 2x16 build: repeat 1-4
    b_int_req = 1;
    step();
    b_int_req = 0;
    check("b_state", b_state, 2'b01);
    check("b_start", b_start, 2'b11);
    check("b_in_ready", b_bus.in_ready, 1'b1);
    b_bus.lane_ready = 2'b11; b_bus.in_valid = 1; b_bus.in_data = 32'hBEEF1234;
    step();
    b_bus.in_valid = 0;
    check("b_lane_data", b_bus.lane_data, 32'hBEEF1234);
    check("b_lane_valid", b_bus.lane_valid, 2'b11);
    b_bus.lane_ready = 2'b10;
    #1;
    check("b_in_ready_stall", b_bus.in_ready, 1'b0);
    b_bus.lane_ready = 2'b11;
    #1;
    check("b_in_ready_release", b_bus.in_ready, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      b_bus.in_valid = 1; b_bus.in_data = 32'h00010001 * k; b_bus.in_eob = 2'b01;
      step();
      check($sformatf("b_start_w%0d", k), b_start, (k < 4) ? 2'b01 : 2'b00);
      check($sformatf("b_finish_w%0d", k), b_finish, (k < 4) ? 2'b00 : 2'b01);
    end
    b_bus.in_valid = 0; b_bus.in_eob = 0;
    step();
    b_bus.in_valid = 1; b_bus.in_data = 32'hCAFE0000;
    step();
    b_bus.in_valid = 0;
    check("b_drop_valid", b_bus.lane_valid, 2'b10);
    check("b_drop_data", b_bus.lane_data, 32'hCAFE0004);
    check("b_err", b_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
